// File: rtl/life_event_ctrl_if.sv
// Signal bundle between collision/pickup logic, the lives counter and life_event_ctrl.
// GAME_PAUSE_EN adds the pause level input.
interface life_event_ctrl_if #(
    parameter int N_SRC = 4
);
    logic             start;
    logic [N_SRC-1:0] hit_req;
    logic [N_SRC-1:0] hit_ack;
    logic             pickup_req;
    logic             pickup_ack;
    logic [1:0]       lives_counter;
    logic             lose_game;
    logic             lose_life;
    logic             extralife;
    logic             powerup;
    logic             lives_reset;
    logic [1:0]       state;
    logic             invuln;
`ifdef GAME_PAUSE_EN
    logic             pause;
`endif

    // Game-side requesters and the lives counter drive the controller.
    modport master (
        output start, hit_req, pickup_req, lives_counter, lose_game,
`ifdef GAME_PAUSE_EN
        output pause,
`endif
        input  hit_ack, pickup_ack, lose_life, extralife, powerup, lives_reset, state, invuln
    );

    modport slave (
        input  start, hit_req, pickup_req, lives_counter, lose_game,
`ifdef GAME_PAUSE_EN
        input  pause,
`endif
        output hit_ack, pickup_ack, lose_life, extralife, powerup, lives_reset, state, invuln
    );
endinterface

// File: rtl/life_event_ctrl.sv
// Game-flow controller: round-robin hit arbitration, pickup pulses, invulnerability window.
// Optional GAME_PAUSE_EN adds a pause input that freezes PLAY/RESPAWN progress.
module life_event_ctrl #(
    parameter int N_SRC         = 4,
    parameter int INVULN_FRAMES = 120,
    parameter int TMR_W         = 8
) (
    input  logic              frame_clk,
    input  logic              Reset_n,
    life_event_ctrl_if.slave  bus
);
    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_RESPAWN = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]   hit_ack_q, hit_ack_d;
    logic               lose_life_q, lose_life_d;
    logic               pickup_q, pickup_d;
    logic               lives_reset_q, lives_reset_d;

    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [N_SRC-1:0]   grant_oh;
    logic               loss;
    logic               paused;

    assign loss = bus.lose_game | (bus.lives_counter == 2'd0);

`ifdef GAME_PAUSE_EN
    assign paused = bus.pause;
`else
    assign paused = 1'b0;
`endif

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        int           cand;
        logic [PTR_W-1:0] cand_idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 1; off <= N_SRC; off++) begin
            cand = int'(rr_ptr_q) + off;
            if (cand >= N_SRC) begin
                cand = cand - N_SRC;
            end
            cand_idx = PTR_W'(cand);
            if (!grant_vld && bus.hit_req[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_grant_oh
            assign grant_oh[gi] = grant_vld && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        rr_ptr_d      = rr_ptr_q;
        hit_ack_d     = '0;
        lose_life_d   = 1'b0;
        pickup_d      = 1'b0;
        lives_reset_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY, S_RESPAWN: begin
                if (loss) begin
                    state_d = S_OVER;
                end else if (!paused) begin
                    if (grant_vld) begin
                        hit_ack_d = grant_oh;
                        rr_ptr_d  = grant_idx;
                    end
                    if (state_q == S_PLAY) begin
                        // A real hit takes the cycle; a concurrent pickup is served next cycle.
                        if (grant_vld) begin
                            lose_life_d = 1'b1;
                            timer_d     = TMR_W'(INVULN_FRAMES);
                            state_d     = S_RESPAWN;
                        end else begin
                            pickup_d = bus.pickup_req;
                        end
                    end else begin
                        pickup_d = bus.pickup_req;
                        if (timer_q <= TMR_W'(1)) begin
                            timer_d = '0;
                            state_d = S_PLAY;
                        end else begin
                            timer_d = timer_q - TMR_W'(1);
                        end
                    end
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    lives_reset_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            rr_ptr_q      <= PTR_W'(N_SRC - 1);
            hit_ack_q     <= '0;
            lose_life_q   <= 1'b0;
            pickup_q      <= 1'b0;
            lives_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rr_ptr_q      <= rr_ptr_d;
            hit_ack_q     <= hit_ack_d;
            lose_life_q   <= lose_life_d;
            pickup_q      <= pickup_d;
            lives_reset_q <= lives_reset_d;
        end
    end

    assign bus.hit_ack     = hit_ack_q;
    assign bus.lose_life   = lose_life_q;
    assign bus.pickup_ack  = pickup_q;
    assign bus.extralife   = pickup_q;
    assign bus.powerup     = pickup_q;
    assign bus.lives_reset = lives_reset_q;
    assign bus.state       = state_q;
    assign bus.invuln      = (state_q == S_RESPAWN);

endmodule

// File: tb/tb_life_event_ctrl.sv
// Table-driven bench for life_event_ctrl with a queue of expected output records.
// Covers GAME_PAUSE_EN freezing when that macro is defined.
module tb_life_event_ctrl;
    logic frame_clk;
    logic Reset_n;

    life_event_ctrl_if #(.N_SRC(4)) bus ();

    life_event_ctrl #(
        .N_SRC(4),
        .INVULN_FRAMES(120),
        .TMR_W(8)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (bus)
    );

    typedef struct {
        logic       st;
        logic [3:0] hit;
        logic       pk;
        logic [1:0] lives;
        logic       lg;
        logic [3:0] e_ack;
        logic       e_ll;
        logic       e_pk;
        logic       e_lr;
        logic [1:0] e_st;
    } vec_t;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic st, logic [3:0] hit, logic pk, logic [1:0] lives, logic lg,
                                logic [3:0] e_ack, logic e_ll, logic e_pk, logic e_lr,
                                logic [1:0] e_st);
        vec_t v;
        v.st = st; v.hit = hit; v.pk = pk; v.lives = lives; v.lg = lg;
        v.e_ack = e_ack; v.e_ll = e_ll; v.e_pk = e_pk; v.e_lr = e_lr; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input vec_t e);
        chk("hit_ack",     32'(bus.hit_ack),     32'(e.e_ack));
        chk("lose_life",   32'(bus.lose_life),   32'(e.e_ll));
        chk("pickup_ack",  32'(bus.pickup_ack),  32'(e.e_pk));
        chk("extralife",   32'(bus.extralife),   32'(e.e_pk));
        chk("powerup",     32'(bus.powerup),     32'(e.e_pk));
        chk("lives_reset", 32'(bus.lives_reset), 32'(e.e_lr));
        chk("state",       32'(bus.state),       32'(e.e_st));
        chk("invuln",      32'(bus.invuln),      32'(e.e_st == 2'd2));
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge frame_clk);
        bus.start         = v.st;
        bus.hit_req       = v.hit;
        bus.pickup_req    = v.pk;
        bus.lives_counter = v.lives;
        bus.lose_game     = v.lg;
        exp_q.push_back(v);
        @(posedge frame_clk);
        #1;
        e = exp_q.pop_front();
        $display("t=%0t in st=%b hit=%b pk=%b lives=%0d lg=%b | out state=%0d ack=%b ll=%b pk=%b lr=%b",
                 $time, v.st, v.hit, v.pk, v.lives, v.lg, bus.state, bus.hit_ack,
                 bus.lose_life, bus.pickup_ack, bus.lives_reset);
        check_outputs(e);
    endtask

    vec_t tbl_a[5];
    vec_t tbl_b[6];
    vec_t tbl_c[8];

    initial begin
        // IDLE ignores requests; start enters PLAY; first grant from reset pointer is src1.
        tbl_a[0] = mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd0);
        tbl_a[1] = mk(0, 4'b1010, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd0);
        tbl_a[2] = mk(0, 4'b0000, 1, 3, 0, 4'b0000, 0, 0, 0, 2'd0);
        tbl_a[3] = mk(1, 4'b1010, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd1);
        tbl_a[4] = mk(0, 4'b1010, 0, 3, 0, 4'b0010, 1, 0, 0, 2'd2);
        // PLAY pickup at full lives, then hit beats concurrent pickup, then RESPAWN absorbs hits.
        tbl_b[0] = mk(0, 4'b0000, 1, 3, 0, 4'b0000, 0, 1, 0, 2'd1);
        tbl_b[1] = mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd1);
        tbl_b[2] = mk(0, 4'b0100, 1, 3, 0, 4'b0100, 1, 0, 0, 2'd2);
        tbl_b[3] = mk(0, 4'b0000, 1, 3, 0, 4'b0000, 0, 1, 0, 2'd2);
        tbl_b[4] = mk(0, 4'b0001, 0, 3, 0, 4'b0001, 0, 0, 0, 2'd2);
        tbl_b[5] = mk(0, 4'b0110, 1, 3, 0, 4'b0010, 0, 1, 0, 2'd2);
        // Loss to OVER with no acks, restart pulse, held start re-enters PLAY, lose_game path.
        tbl_c[0] = mk(1, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd1);
        tbl_c[1] = mk(0, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 0, 2'd3);
        tbl_c[2] = mk(0, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 0, 2'd3);
        tbl_c[3] = mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1, 2'd0);
        tbl_c[4] = mk(1, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd1);
        tbl_c[5] = mk(0, 4'b0010, 1, 3, 1, 4'b0000, 0, 0, 0, 2'd3);
        tbl_c[6] = mk(1, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 1, 2'd0);
        tbl_c[7] = mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd0);

        Reset_n           = 1'b0;
        bus.start         = 1'b0;
        bus.hit_req       = '0;
        bus.pickup_req    = 1'b0;
        bus.lives_counter = 2'd3;
        bus.lose_game     = 1'b0;
`ifdef GAME_PAUSE_EN
        bus.pause         = 1'b0;
`endif
        repeat (3) @(posedge frame_clk);
        #1;
        check_outputs(mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd0));
        @(negedge frame_clk);
        Reset_n = 1'b1;

        foreach (tbl_a[i]) step(tbl_a[i]);

        // First window: exactly 120 cycles in RESPAWN.
        for (int i = 0; i < 119; i++) step(mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd2));
        step(mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd1));

        foreach (tbl_b[i]) step(tbl_b[i]);

        // Absorbed hits must not reload the timer: window still ends 120 cycles after the hit.
        for (int i = 3; i < 90; i++) step(mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd2));
`ifdef GAME_PAUSE_EN
        bus.pause = 1'b1;
        for (int i = 0; i < 10; i++) step(mk(0, 4'b1111, 1, 3, 0, 4'b0000, 0, 0, 0, 2'd2));
        bus.pause = 1'b0;
`endif
        for (int i = 90; i < 119; i++) step(mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd2));
        step(mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd1));

        // Pointer sits at src1, so 1010 now grants src3.
        step(mk(0, 4'b1010, 0, 3, 0, 4'b1000, 1, 0, 0, 2'd2));
        for (int i = 1; i < 70; i++) step(mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd2));
        step(mk(0, 4'b0000, 1, 3, 0, 4'b0000, 0, 1, 0, 2'd2));

        // Asynchronous reset between edges with timer at 50 and a pickup pulse showing.
        #2;
        bus.hit_req = 4'b1111;
        Reset_n     = 1'b0;
        #1;
        check_outputs(mk(0, 4'b0000, 0, 3, 0, 4'b0000, 0, 0, 0, 2'd0));
        @(negedge frame_clk);
        bus.hit_req    = '0;
        bus.pickup_req = 1'b0;
        Reset_n        = 1'b1;

        foreach (tbl_c[i]) step(tbl_c[i]);

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
